// File: rtl/syn_fifo_prog.sv
// syn_fifo_prog: single-clock synchronous FIFO with arbitrary depth (>= 2),
// occupancy count, programmable almost-full/almost-empty thresholds and
// registered overflow/underflow pulses.
// Optional macro SYN_FIFO_FWFT_EN: first-word-fall-through read port
// (data_out shows the head word with zero latency). Undefined: data_out is
// registered with one cycle of read latency.
module syn_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            wr_en,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_empty,
    output logic                            almost_full,
    output logic [$clog2(DATA_DEPTH+1)-1:0] data_count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int PTR_W = $clog2(DATA_DEPTH);
    localparam int CNT_W = $clog2(DATA_DEPTH + 1);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("syn_fifo_prog: DATA_WIDTH must be >= 1");
    end
    if (DATA_DEPTH < 2) begin : g_bad_depth
        $error("syn_fifo_prog: DATA_DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DATA_DEPTH) begin : g_bad_af
        $error("syn_fifo_prog: AF_LEVEL must be in 1..DATA_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DATA_DEPTH) begin : g_bad_ae
        $error("syn_fifo_prog: AE_LEVEL must be in 0..DATA_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DATA_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Status flags straight from the occupancy count.
    always_comb begin
        empty        = (data_count == '0);
        full         = (data_count == CNT_W'(DATA_DEPTH));
        almost_full  = (data_count >= CNT_W'(AF_LEVEL));
        almost_empty = (data_count <= CNT_W'(AE_LEVEL));
    end

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer advance on accepted transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // Occupancy: net change of accepted write and read.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_count <= '0;
        end else if (wr_acc && !rd_acc) begin
            data_count <= data_count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            data_count <= data_count - CNT_W'(1);
        end
    end

    // One-cycle pulses for rejected requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    // Head word presented combinationally; don't-care while empty.
    always_comb begin
        data_out = mem[rd_ptr];
    end
`else
    // Registered read port; holds value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Self-checking bench for syn_fifo_prog (DEPTH=12, AF=10, AE=2).
// Honours SYN_FIFO_FWFT_EN for data_out expectations.
module tb_syn_fifo_prog;

    localparam int W     = 8;
    localparam int DEPTH = 12;
    localparam int AF    = 10;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  data_out;
    logic          empty, full, almost_empty, almost_full;
    logic [CW-1:0] data_count;
    logic          overflow, underflow;

    syn_fifo_prog #(
        .DATA_WIDTH(W),
        .DATA_DEPTH(DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_out(data_out),
        .empty(empty),
        .full(full),
        .almost_empty(almost_empty),
        .almost_full(almost_full),
        .data_count(data_count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: a plain queue of stored words.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    bit           m_ovf  = 0;
    bit           m_unf  = 0;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [W-1:0] din;
        int           cnt;
        bit           emp;
        bit           ful;
        bit           af;
        bit           ae;
        bit           ovf;
        bit           unf;
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all(input string tag);
        int c;
        c = q.size();
        check({tag, ":count"}, int'(data_count), c);
        check({tag, ":empty"}, int'(empty), int'(c == 0));
        check({tag, ":full"}, int'(full), int'(c == DEPTH));
        check({tag, ":almost_full"}, int'(almost_full), int'(c >= AF));
        check({tag, ":almost_empty"}, int'(almost_empty), int'(c <= AE));
        check({tag, ":overflow"}, int'(overflow), int'(m_ovf));
        check({tag, ":underflow"}, int'(underflow), int'(m_unf));
`ifdef SYN_FIFO_FWFT_EN
        if (c != 0) check({tag, ":data_out"}, int'(data_out), int'(q[0]));
`else
        check({tag, ":data_out"}, int'(data_out), int'(m_dout));
`endif
    endtask

    // One clock with the given request; model updated from pre-edge occupancy.
    task automatic step(input string tag, input bit wr, input bit rd, input logic [W-1:0] din);
        bit wa, ra;
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        #1;
        m_ovf = wr && (q.size() == DEPTH);
        m_unf = rd && (q.size() == 0);
        wa    = wr && (q.size() != DEPTH);
        ra    = rd && (q.size() != 0);
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(din);
        compare_all(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input string tag, input bit wr);
        rst     = 1'b1;
        wr_en   = wr;
        rd_en   = 1'b0;
        data_in = 8'hEE;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        q.delete();
        m_dout = '0;
        m_ovf  = 0;
        m_unf  = 0;
        compare_all(tag);
    endtask

    task automatic fill_to(input string tag, input int n);
        while (q.size() < n) step(tag, 1, 0, W'($urandom));
    endtask

    initial begin
        int c;
        // Fill 12 words then one rejected write; drain 12 then one rejected read.
        for (int i = 0; i < 13; i++) begin
            c = (i < 12) ? i + 1 : 12;
            vecs[i] = '{wr: 1, rd: 0, din: W'(i + 1), cnt: c, emp: (c == 0), ful: (c == DEPTH),
                        af: (c >= AF), ae: (c <= AE), ovf: (i == 12), unf: 0, dout: '0};
        end
        for (int i = 0; i < 13; i++) begin
            c = (i < 12) ? 11 - i : 0;
            vecs[13 + i] = '{wr: 0, rd: 1, din: '0, cnt: c, emp: (c == 0), ful: (c == DEPTH),
                             af: (c >= AF), ae: (c <= AE), ovf: 0, unf: (i == 12),
                             dout: W'((i < 12) ? i + 1 : 12)};
        end

        do_reset("reset", 0);

        // Table-driven fill/drain.
        foreach (vecs[k]) begin
`ifdef SYN_FIFO_FWFT_EN
            if (vecs[k].rd && !vecs[k].unf) check("tbl:fwft_head", int'(data_out), int'(vecs[k].dout));
`endif
            step("tbl", vecs[k].wr, vecs[k].rd, vecs[k].din);
            check("tbl:count", int'(data_count), vecs[k].cnt);
            check("tbl:empty", int'(empty), int'(vecs[k].emp));
            check("tbl:full", int'(full), int'(vecs[k].ful));
            check("tbl:af", int'(almost_full), int'(vecs[k].af));
            check("tbl:ae", int'(almost_empty), int'(vecs[k].ae));
            check("tbl:ovf", int'(overflow), int'(vecs[k].ovf));
            check("tbl:unf", int'(underflow), int'(vecs[k].unf));
`ifndef SYN_FIFO_FWFT_EN
            check("tbl:dout", int'(data_out), int'(vecs[k].dout));
`endif
        end

        // Idle cycle: error pulses must drop after one cycle.
        step("idle", 0, 0, '0);

        // Write 8 / read 8, twice: pointers wrap past index 11.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) step("wrap_wr", 1, 0, W'(8'h40 + r * 8 + i));
            for (int i = 0; i < 8; i++) step("wrap_rd", 0, 1, '0);
        end

        // Simultaneous read/write at count 6, then at full.
        fill_to("pre6", 6);
        for (int i = 0; i < 20; i++) step("rw6", 1, 1, W'($urandom));
        fill_to("pre12", 12);
        step("rw_full", 1, 1, 8'h99);
        step("idle2", 0, 0, '0);

        // Simultaneous read/write when empty: write wins, underflow pulses.
        while (q.size() > 0) step("drain", 0, 1, '0);
        step("rw_empty", 1, 1, 8'h77);
        step("rd_one", 0, 1, '0);

        // Reset mid-stream with wr_en high.
        fill_to("pre7", 7);
        do_reset("mid_reset", 1);
        step("post_wr", 1, 0, 8'h3C);
        step("post_rd", 0, 1, '0);
`ifndef SYN_FIFO_FWFT_EN
        check("post_reset_data", int'(data_out), 32'h3C);
`endif

`ifdef SYN_FIFO_FWFT_EN
        // Zero-latency head presentation.
        step("fwft_w1", 1, 0, 8'hA5);
        check("fwft_first", int'(data_out), 32'hA5);
        step("fwft_w2", 1, 0, 8'h5A);
        step("fwft_pop1", 0, 1, '0);
        check("fwft_second", int'(data_out), 32'h5A);
        step("fwft_pop2", 0, 1, '0);
        check("fwft_empty", int'(empty), 1);
`endif

        // Randomised traffic with shifting write/read bias.
        for (int ph = 0; ph < 3; ph++) begin
            int pw, pr;
            pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 150; i++)
                step("rand", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
